// File: rtl/mips_dbg_pkg.sv
// -----------------------------------------------------------------------------
// mips_dbg_pkg
// Shared definitions for the end-of-program monitor / memory dumper of the
// multi-cycle MIPS core.
//   state_t        : dumper FSM states (RUN, REQ, CAP, SEND, DONE)
//   DEFAULT_END_PC : PC that marks program completion by default
//   word_idx_w()   : width of a counter that indexes n items (at least 1 bit)
// -----------------------------------------------------------------------------
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [31:0] DEFAULT_END_PC = 32'h0000_007C;

    // $clog2(n) collapses to 0 for n == 1; a zero-width counter is not legal,
    // so the result is clamped to one bit.
    function automatic int word_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that counts enabled cycles and sticks at all-ones.
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-high reset, clears the count
//   en    in  count this cycle
//   count out current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_watch_dump_ctrl.sv
// -----------------------------------------------------------------------------
// pc_watch_dump_ctrl
// Watches the fetched PC for END_PC (or an optional cycle-budget timeout),
// then freezes the core and streams DUMP_WORDS words of data memory starting
// at DUMP_BASE out on a valid/ready interface.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   pc, pc_valid    fetched PC and its qualifier (only looked at in RUN)
//   hold_cpu        freeze request, high from the cycle after the trigger
//   mem_rd_en       one-cycle read strobe, only in REQ
//   mem_rd_addr     word address of the read (0 when not reading)
//   mem_rd_data     read data, valid one cycle after mem_rd_en
//   out_valid       out_data holds a dumped word
//   out_ready       sink accepts the word
//   out_data        dumped word
//   out_eol         last word of a line, or last word overall
//   out_last        final word of the dump
//   done            dump finished (sticky until reset)
//   timed_out       the trigger came from the timeout (sticky until reset)
//   cycle_count     RUN cycles before the trigger, saturating
// -----------------------------------------------------------------------------
module pc_watch_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int              DATA_W         = 32,
    parameter int              PC_W           = 32,
    parameter int              MEM_AW         = 10,
    parameter logic [PC_W-1:0] END_PC         = PC_W'(DEFAULT_END_PC),
    parameter int              DUMP_BASE      = 32,
    parameter int              DUMP_WORDS     = 96,
    parameter int              WORDS_PER_LINE = 16,
    parameter int              TIMEOUT_CYC    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc,
    input  logic              pc_valid,
    output logic              hold_cpu,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_last,
    output logic              done,
    output logic              timed_out,
    output logic [31:0]       cycle_count
);

    localparam int IDX_W  = word_idx_w(DUMP_WORDS);
    localparam int LINE_W = word_idx_w(WORDS_PER_LINE);

    // Illegal configurations are rejected at elaboration time.
    generate
        if (DUMP_WORDS < 1) begin : g_err_words
            $error("pc_watch_dump_ctrl: DUMP_WORDS must be >= 1");
        end
        if (WORDS_PER_LINE < 1) begin : g_err_line
            $error("pc_watch_dump_ctrl: WORDS_PER_LINE must be >= 1");
        end
        if ((longint'(DUMP_BASE) + longint'(DUMP_WORDS)) > (longint'(1) << MEM_AW)) begin : g_err_wrap
            $error("pc_watch_dump_ctrl: dump window exceeds the memory address space");
        end
    endgenerate

    state_t              state;
    state_t              state_nx;
    logic [IDX_W-1:0]    idx;
    logic [LINE_W-1:0]   line_pos;
    logic                trig_pc;
    logic                trig_to;
    logic                trigger;
    logic                is_last;
    logic                line_end;
    logic                word_taken;

    assign trig_pc    = pc_valid && (pc == END_PC);
    assign trig_to    = (TIMEOUT_CYC != 0) && (cycle_count == 32'(TIMEOUT_CYC - 1));
    assign trigger    = (state == ST_RUN) && (trig_pc || trig_to);
    assign is_last    = (idx == IDX_W'(DUMP_WORDS - 1));
    // line_pos tracks idx modulo WORDS_PER_LINE without a divider.
    assign line_end   = (line_pos == LINE_W'(WORDS_PER_LINE - 1));
    assign word_taken = (state == ST_SEND) && out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RUN:  if (trig_pc || trig_to) state_nx = ST_REQ;
            ST_REQ:  state_nx = ST_CAP;
            ST_CAP:  state_nx = ST_SEND;
            ST_SEND: if (out_ready) state_nx = is_last ? ST_DONE : ST_REQ;
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        hold_cpu    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        out_valid   = 1'b0;
        out_eol     = 1'b0;
        out_last    = 1'b0;
        done        = 1'b0;
        unique case (state)
            ST_RUN: begin
            end
            ST_REQ: begin
                hold_cpu    = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = MEM_AW'(DUMP_BASE) + MEM_AW'(idx);
            end
            ST_CAP: begin
                hold_cpu = 1'b1;
            end
            ST_SEND: begin
                hold_cpu  = 1'b1;
                out_valid = 1'b1;
                out_last  = is_last;
                out_eol   = line_end || is_last;
            end
            ST_DONE: begin
                hold_cpu = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Word index and position within the current output line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            line_pos <= '0;
        end else if (word_taken && !is_last) begin
            idx      <= idx + IDX_W'(1);
            line_pos <= line_end ? '0 : line_pos + LINE_W'(1);
        end
    end

    // Captured word; held unchanged through SEND so it is stable under
    // backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
        end else if (state == ST_CAP) begin
            out_data <= mem_rd_data;
        end
    end

    // A simultaneous END_PC hit takes precedence over the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timed_out <= 1'b0;
        end else if ((state == ST_RUN) && trig_to && !trig_pc) begin
            timed_out <= 1'b1;
        end
    end

    // The trigger cycle itself is not counted, so the count freezes at the
    // value it held when the trigger fired.
    sat_counter #(
        .W(32)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    ((state == ST_RUN) && !trigger),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_pc_watch_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_watch_dump_ctrl
// Directed bench for pc_watch_dump_ctrl. Three instances share the inputs and
// differ only in TIMEOUT_CYC (0, 50, 20); each has its own memory model that
// returns 0xA000_0000 + address one cycle after a read strobe.
// -----------------------------------------------------------------------------
module tb_pc_watch_dump_ctrl;

    localparam int NU = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        out_ready;

    logic        hold_cpu    [NU];
    logic        mem_rd_en   [NU];
    logic [9:0]  mem_rd_addr [NU];
    logic [31:0] mem_rd_data [NU];
    logic        out_valid   [NU];
    logic [31:0] out_data    [NU];
    logic        out_eol     [NU];
    logic        out_last    [NU];
    logic        done        [NU];
    logic        timed_out   [NU];
    logic [31:0] cycle_count [NU];

    int n_checks = 0;
    int n_fail   = 0;

    // Capture state written by collect()
    logic [9:0]  cap_addr [8];
    logic [31:0] cap_data [8];
    logic        cap_eol  [8];
    logic        cap_last [8];
    int          n_rd;
    int          n_wd;
    int          hs_cycle;
    int          stall_cycles;
    logic [31:0] stall_val;
    logic        stall_bad;
    logic        got_done;
    logic        got_valid_after;
    logic        timeout_hit;

    logic [3:0]  exp_eol  = 4'b1010;
    logic [3:0]  exp_last = 4'b1000;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NU; g++) begin : g_dut
            pc_watch_dump_ctrl #(
                .DATA_W         (32),
                .PC_W           (32),
                .MEM_AW         (10),
                .END_PC         (32'h7C),
                .DUMP_BASE      (32),
                .DUMP_WORDS     (4),
                .WORDS_PER_LINE (2),
                .TIMEOUT_CYC    ((g == 0) ? 0 : ((g == 1) ? 50 : 20))
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .pc          (pc),
                .pc_valid    (pc_valid),
                .hold_cpu    (hold_cpu[g]),
                .mem_rd_en   (mem_rd_en[g]),
                .mem_rd_addr (mem_rd_addr[g]),
                .mem_rd_data (mem_rd_data[g]),
                .out_valid   (out_valid[g]),
                .out_ready   (out_ready),
                .out_data    (out_data[g]),
                .out_eol     (out_eol[g]),
                .out_last    (out_last[g]),
                .done        (done[g]),
                .timed_out   (timed_out[g]),
                .cycle_count (cycle_count[g])
            );
        end
    endgenerate

    // Memory model: data only valid the cycle after a strobe, garbage otherwise.
    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            mem_rd_data[u] <= mem_rd_en[u] ? (32'hA000_0000 + 32'(mem_rd_addr[u])) : 32'hDEAD_BEEF;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pc        = 32'h0;
        pc_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Follows one dump on instance u starting from its first REQ cycle,
    // recording reads and handshakes. Word stall_word is held off with
    // out_ready low for stall_len cycles.
    task automatic collect(input int u, input int stall_word, input int stall_len, input int budget);
        int  st;
        logic in_stall;
        logic eol_h, last_h;
        st = 0; in_stall = 1'b0; n_rd = 0; n_wd = 0; hs_cycle = -1;
        stall_cycles = 0; stall_val = 32'h0; stall_bad = 1'b0;
        got_done = 1'b0; got_valid_after = 1'b1; timeout_hit = 1'b1;
        eol_h = 1'b0; last_h = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (mem_rd_en[u]) begin
                if (n_rd < 8) cap_addr[n_rd] = mem_rd_addr[u];
                n_rd++;
                if (in_stall) stall_bad = 1'b1;
            end
            if (in_stall && !out_valid[u]) stall_bad = 1'b1;
            if (out_valid[u]) begin
                if (n_wd == stall_word && st < stall_len) begin
                    out_ready = 1'b0;
                    if (!in_stall) begin
                        stall_val = out_data[u];
                        eol_h     = out_eol[u];
                        last_h    = out_last[u];
                    end else if (out_data[u] !== stall_val || out_eol[u] !== eol_h || out_last[u] !== last_h) begin
                        stall_bad = 1'b1;
                    end
                    in_stall = 1'b1;
                    st++;
                    stall_cycles++;
                end else begin
                    if (in_stall && out_data[u] !== stall_val) stall_bad = 1'b1;
                    in_stall  = 1'b0;
                    out_ready = 1'b1;
                    if (n_wd < 8) begin
                        cap_data[n_wd] = out_data[u];
                        cap_eol[n_wd]  = out_eol[u];
                        cap_last[n_wd] = out_last[u];
                    end
                    n_wd++;
                    if (out_last[u]) begin
                        hs_cycle = c;
                        step();
                        got_done        = done[u];
                        got_valid_after = out_valid[u];
                        timeout_hit     = 1'b0;
                        return;
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = 32'h0; pc_valid = 1'b0; out_ready = 1'b1;
        #2;
        for (int u = 0; u < NU; u++) begin
            n_checks++; if (hold_cpu[u] !== 1'b0) begin n_fail++; $display("FAIL reset_hold[%0d]: got %b want 0", u, hold_cpu[u]); end
            n_checks++; if (mem_rd_en[u] !== 1'b0 || mem_rd_addr[u] !== 10'd0) begin n_fail++; $display("FAIL reset_rd[%0d]: got en=%b addr=%0d want 0/0", u, mem_rd_en[u], mem_rd_addr[u]); end
            n_checks++; if (out_valid[u] !== 1'b0 || out_data[u] !== 32'h0 || out_eol[u] !== 1'b0 || out_last[u] !== 1'b0) begin n_fail++; $display("FAIL reset_out[%0d]: got v=%b d=%h e=%b l=%b want all 0", u, out_valid[u], out_data[u], out_eol[u], out_last[u]); end
            n_checks++; if (done[u] !== 1'b0 || timed_out[u] !== 1'b0 || cycle_count[u] !== 32'd0) begin n_fail++; $display("FAIL reset_status[%0d]: got done=%b to=%b cnt=%0d want 0", u, done[u], timed_out[u], cycle_count[u]); end
        end
        step();
        reset = 1'b0;
        step(); step(); step();
        n_checks++; if (cycle_count[0] !== 32'd3) begin n_fail++; $display("FAIL count_after_reset: got %0d want 3", cycle_count[0]); end
    endtask

    task automatic test_normal_dump();
        do_reset();
        for (int a = 0; a <= 32'h7C; a += 4) begin
            pc = 32'(a); pc_valid = 1'b1;
            n_checks++; if (hold_cpu[0] !== 1'b0) begin n_fail++; $display("FAIL hold_early pc=%h: got %b want 0", pc, hold_cpu[0]); end
            step();
        end
        pc_valid = 1'b0;
        n_checks++; if (hold_cpu[0] !== 1'b1) begin n_fail++; $display("FAIL hold_after_trig: got %b want 1", hold_cpu[0]); end
        n_checks++; if (cycle_count[0] !== 32'd31) begin n_fail++; $display("FAIL normal_count: got %0d want 31", cycle_count[0]); end
        n_checks++; if (timed_out[0] !== 1'b0) begin n_fail++; $display("FAIL normal_timed_out: got %b want 0", timed_out[0]); end
        collect(0, -1, 0, 60);
        n_checks++; if (timeout_hit !== 1'b0) begin n_fail++; $display("FAIL normal_finish: dump did not finish got %b want 0", timeout_hit); end
        n_checks++; if (n_rd !== 4 || n_wd !== 4) begin n_fail++; $display("FAIL normal_counts: got rd=%0d wd=%0d want 4/4", n_rd, n_wd); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_addr[i] !== 10'(32 + i)) begin n_fail++; $display("FAIL normal_addr[%0d]: got %0d want %0d", i, cap_addr[i], 32 + i); end
            n_checks++; if (cap_data[i] !== 32'hA000_0020 + 32'(i)) begin n_fail++; $display("FAIL normal_data[%0d]: got %h want %h", i, cap_data[i], 32'hA000_0020 + 32'(i)); end
            n_checks++; if (cap_eol[i] !== exp_eol[i] || cap_last[i] !== exp_last[i]) begin n_fail++; $display("FAIL normal_marks[%0d]: got eol=%b last=%b want %b/%b", i, cap_eol[i], cap_last[i], exp_eol[i], exp_last[i]); end
        end
        n_checks++; if (hs_cycle !== 11) begin n_fail++; $display("FAIL normal_throughput: last handshake cycle got %0d want 11", hs_cycle); end
        n_checks++; if (got_done !== 1'b1 || got_valid_after !== 1'b0) begin n_fail++; $display("FAIL normal_done: got done=%b valid=%b want 1/0", got_done, got_valid_after); end
        n_checks++; if (cycle_count[0] !== 32'd31) begin n_fail++; $display("FAIL normal_count_frozen: got %0d want 31", cycle_count[0]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        pc = 32'h7C; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        collect(0, 2, 5, 80);
        n_checks++; if (timeout_hit !== 1'b0) begin n_fail++; $display("FAIL bp_finish: dump did not finish got %b want 0", timeout_hit); end
        n_checks++; if (stall_cycles !== 5) begin n_fail++; $display("FAIL bp_stall_len: got %0d want 5", stall_cycles); end
        n_checks++; if (stall_bad !== 1'b0) begin n_fail++; $display("FAIL bp_stable: output moved or read issued during stall got %b want 0", stall_bad); end
        n_checks++; if (stall_val !== 32'hA000_0022) begin n_fail++; $display("FAIL bp_word: got %h want a0000022", stall_val); end
        n_checks++; if (n_rd !== 4 || n_wd !== 4) begin n_fail++; $display("FAIL bp_counts: got rd=%0d wd=%0d want 4/4", n_rd, n_wd); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_data[i] !== 32'hA000_0020 + 32'(i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, cap_data[i], 32'hA000_0020 + 32'(i)); end
        end
        n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", got_done); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (49) step();
        n_checks++; if (hold_cpu[1] !== 1'b0 || cycle_count[1] !== 32'd49) begin n_fail++; $display("FAIL to_pre: got hold=%b cnt=%0d want 0/49", hold_cpu[1], cycle_count[1]); end
        step();
        n_checks++; if (hold_cpu[1] !== 1'b1 || timed_out[1] !== 1'b1) begin n_fail++; $display("FAIL to_trig: got hold=%b to=%b want 1/1", hold_cpu[1], timed_out[1]); end
        n_checks++; if (cycle_count[1] !== 32'd49) begin n_fail++; $display("FAIL to_count: got %0d want 49", cycle_count[1]); end
        collect(1, -1, 0, 60);
        n_checks++; if (timeout_hit !== 1'b0 || n_wd !== 4) begin n_fail++; $display("FAIL to_dump: got timeout=%b words=%0d want 0/4", timeout_hit, n_wd); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_data[i] !== 32'hA000_0020 + 32'(i)) begin n_fail++; $display("FAIL to_data[%0d]: got %h want %h", i, cap_data[i], 32'hA000_0020 + 32'(i)); end
        end
        n_checks++; if (timed_out[1] !== 1'b1 || cycle_count[1] !== 32'd49 || done[1] !== 1'b1) begin n_fail++; $display("FAIL to_end: got to=%b cnt=%0d done=%b want 1/49/1", timed_out[1], cycle_count[1], done[1]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (19) step();
        pc = 32'h7C; pc_valid = 1'b1;
        n_checks++; if (cycle_count[2] !== 32'd19 || hold_cpu[2] !== 1'b0) begin n_fail++; $display("FAIL sim_pre: got cnt=%0d hold=%b want 19/0", cycle_count[2], hold_cpu[2]); end
        step();
        pc_valid = 1'b0;
        n_checks++; if (hold_cpu[2] !== 1'b1 || timed_out[2] !== 1'b0) begin n_fail++; $display("FAIL sim_trig: got hold=%b to=%b want 1/0", hold_cpu[2], timed_out[2]); end
        collect(2, -1, 0, 60);
        n_checks++; if (timeout_hit !== 1'b0 || n_wd !== 4 || got_done !== 1'b1) begin n_fail++; $display("FAIL sim_dump: got timeout=%b words=%0d done=%b want 0/4/1", timeout_hit, n_wd, got_done); end
        n_checks++; if (cap_data[0] !== 32'hA000_0020 || cap_data[3] !== 32'hA000_0023) begin n_fail++; $display("FAIL sim_data: got %h..%h want a0000020..a0000023", cap_data[0], cap_data[3]); end
        n_checks++; if (timed_out[2] !== 1'b0 || cycle_count[2] !== 32'd19) begin n_fail++; $display("FAIL sim_end: got to=%b cnt=%0d want 0/19", timed_out[2], cycle_count[2]); end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        pc = 32'h7C; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        repeat (5) step();
        n_checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hA000_0021) begin n_fail++; $display("FAIL mid_pre: got v=%b d=%h want 1/a0000021", out_valid[0], out_data[0]); end
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid[0] !== 1'b0 || out_data[0] !== 32'h0 || out_eol[0] !== 1'b0 || out_last[0] !== 1'b0) begin n_fail++; $display("FAIL mid_async_out: got v=%b d=%h e=%b l=%b want all 0", out_valid[0], out_data[0], out_eol[0], out_last[0]); end
        n_checks++; if (hold_cpu[0] !== 1'b0 || mem_rd_en[0] !== 1'b0 || done[0] !== 1'b0 || cycle_count[0] !== 32'd0) begin n_fail++; $display("FAIL mid_async_ctl: got hold=%b rd=%b done=%b cnt=%0d want 0", hold_cpu[0], mem_rd_en[0], done[0], cycle_count[0]); end
        step();
        reset = 1'b0;
        pc = 32'h7C; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        n_checks++; if (mem_rd_en[0] !== 1'b1 || mem_rd_addr[0] !== 10'd32) begin n_fail++; $display("FAIL mid_restart_rd: got en=%b addr=%0d want 1/32", mem_rd_en[0], mem_rd_addr[0]); end
        collect(0, -1, 0, 60);
        n_checks++; if (timeout_hit !== 1'b0 || n_wd !== 4 || got_done !== 1'b1) begin n_fail++; $display("FAIL mid_restart_dump: got timeout=%b words=%0d done=%b want 0/4/1", timeout_hit, n_wd, got_done); end
        n_checks++; if (cap_data[0] !== 32'hA000_0020 || cap_last[3] !== 1'b1) begin n_fail++; $display("FAIL mid_restart_data: got first=%h last=%b want a0000020/1", cap_data[0], cap_last[3]); end
    endtask

    task automatic test_no_retrigger();
        n_checks++; if (done[0] !== 1'b1) begin n_fail++; $display("FAIL nr_pre_done: got %b want 1", done[0]); end
        pc = 32'h7C; pc_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++; if (mem_rd_en[0] !== 1'b0 || done[0] !== 1'b1 || out_valid[0] !== 1'b0 || hold_cpu[0] !== 1'b1) begin n_fail++; $display("FAIL nr_cycle%0d: got rd=%b done=%b v=%b hold=%b want 0/1/0/1", c, mem_rd_en[0], done[0], out_valid[0], hold_cpu[0]); end
        end
        pc_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_dump();
        test_backpressure();
        test_timeout();
        test_simultaneous();
        test_reset_mid_dump();
        test_no_retrigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
